// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl: central sequencer for the bomb-defusal board.
// Arms every puzzle module through the 3-bit module-state protocol, runs the
// countdown, counts strikes and decides between DEFUSED and EXPLODED.
// Optional feature macro: STRIKE_SPEEDUP_EN (each strike halves the second).
module bomb_game_ctrl #(
  parameter int unsigned N_MOD        = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned GAME_SECONDS = 300,
  parameter int unsigned MAX_STRIKES  = 3,
  parameter int unsigned ARM_TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_MOD-1:0]     mod_activated,
  input  logic [N_MOD-1:0]     mod_failed,
  input  logic [N_MOD-1:0]     mod_solved,
  output logic [3*N_MOD-1:0]   mod_state,
  output logic [2:0]           game_state,
  output logic [9:0]           time_left,
  output logic [1:0]           strikes,
  output logic                 sec_tick,
  output logic                 defused,
  output logic                 exploded,
  output logic                 arm_fault
);

  localparam int unsigned CNT_W  = $clog2(CLK_HZ + 1);
  localparam int unsigned ARM_W  = $clog2(ARM_TIMEOUT + 1);
  localparam int unsigned FCNT_W = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DEFUSED  = 3'd3;
  localparam logic [2:0] S_EXPLODED = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [2:0] MS_IDLE       = 3'b000;
  localparam logic [2:0] MS_ACTIVATING = 3'b001;
  localparam logic [2:0] MS_ACTIVATED  = 3'b010;
  localparam logic [2:0] MS_SOLVED     = 3'b011;

  localparam logic [N_MOD-1:0] ALL_ONES = {N_MOD{1'b1}};

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic               start_q;
  logic               start_rise_c;
  logic [N_MOD-1:0]   ack_q;
  logic [N_MOD-1:0]   ack_d;
  logic [N_MOD-1:0]   solved_q;
  logic [N_MOD-1:0]   solved_d;
  logic [CNT_W-1:0]   tick_q;
  logic [CNT_W-1:0]   tick_d;
  logic [CNT_W-1:0]   div_raw_c;
  logic [CNT_W-1:0]   div_c;
  logic [ARM_W-1:0]   arm_cnt_q;
  logic [ARM_W-1:0]   arm_cnt_d;
  logic [9:0]         time_d;
  logic [1:0]         strikes_d;
  logic               sec_tick_d;
  logic [3*N_MOD-1:0] mod_state_d;
  logic [FCNT_W-1:0]  fail_cnt_c;
  logic [FCNT_W-1:0]  strike_sum_c;

  assign start_rise_c = start & ~start_q;
  assign game_state   = state_q;

  // Length of one game second in clk cycles for the current strike count
  always_comb begin
`ifdef STRIKE_SPEEDUP_EN
    div_raw_c = CNT_W'(CLK_HZ) >> strikes;
`else
    div_raw_c = CNT_W'(CLK_HZ);
`endif
    div_c = (div_raw_c == '0) ? CNT_W'(1) : div_raw_c;
  end

  // Count wrong actions from modules that are still unsolved
  always_comb begin
    fail_cnt_c = '0;
    for (int unsigned i = 0; i < N_MOD; i++) begin
      fail_cnt_c = fail_cnt_c + FCNT_W'(mod_failed[i] & ~solved_q[i]);
    end
    strike_sum_c = FCNT_W'(strikes) + fail_cnt_c;
  end

  // Next game state, counters and per-module state codes
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    solved_d    = solved_q;
    tick_d      = tick_q;
    arm_cnt_d   = arm_cnt_q;
    time_d      = time_left;
    strikes_d   = strikes;
    sec_tick_d  = 1'b0;
    mod_state_d = '0;

    case (state_q)
      S_ARM: begin
        ack_d = ack_q | mod_activated;
        if ((ack_q | mod_activated) == ALL_ONES) begin
          state_d = S_RUN;
        end else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end

      S_RUN: begin
        // Exit decisions use the already-registered masks and counters
        if ((strikes == 2'(MAX_STRIKES)) || (time_left == 10'd0)) begin
          state_d = S_EXPLODED;
        end else if (solved_q == ALL_ONES) begin
          state_d = S_DEFUSED;
        end else begin
          solved_d  = solved_q | mod_solved;
          strikes_d = (strike_sum_c >= FCNT_W'(MAX_STRIKES)) ?
                      2'(MAX_STRIKES) : strike_sum_c[1:0];
          if (tick_q >= (div_c - CNT_W'(1))) begin
            tick_d = '0;
            if (time_left != 10'd0) begin
              time_d     = time_left - 10'd1;
              sec_tick_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
`ifdef STRIKE_SPEEDUP_EN
          // A new strike count starts a fresh, shorter second
          if (strikes_d != strikes) begin
            tick_d = '0;
          end
`endif
        end
      end

      S_IDLE, S_DEFUSED, S_EXPLODED, S_FAULT: begin
        if (start_rise_c) begin
          state_d   = S_ARM;
          ack_d     = '0;
          solved_d  = '0;
          strikes_d = '0;
          tick_d    = '0;
          arm_cnt_d = '0;
          time_d    = 10'(GAME_SECONDS);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    for (int unsigned i = 0; i < N_MOD; i++) begin
      case (state_d)
        S_ARM:   mod_state_d[3*i +: 3] = MS_ACTIVATING;
        S_RUN:   mod_state_d[3*i +: 3] = solved_d[i] ? MS_SOLVED : MS_ACTIVATED;
        default: mod_state_d[3*i +: 3] = MS_IDLE;
      endcase
    end
  end

  // Game state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Masks, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b0;
      ack_q     <= '0;
      solved_q  <= '0;
      tick_q    <= '0;
      arm_cnt_q <= '0;
      time_left <= 10'(GAME_SECONDS);
      strikes   <= '0;
      sec_tick  <= 1'b0;
      mod_state <= '0;
      defused   <= 1'b0;
      exploded  <= 1'b0;
      arm_fault <= 1'b0;
    end else begin
      start_q   <= start;
      ack_q     <= ack_d;
      solved_q  <= solved_d;
      tick_q    <= tick_d;
      arm_cnt_q <= arm_cnt_d;
      time_left <= time_d;
      strikes   <= strikes_d;
      sec_tick  <= sec_tick_d;
      mod_state <= mod_state_d;
      defused   <= (state_d == S_DEFUSED);
      exploded  <= (state_d == S_EXPLODED);
      arm_fault <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// tb_bomb_game_ctrl: directed table, hand sequences and randomized traffic
// checked against a game-rule model of the bomb controller.
module tb_bomb_game_ctrl;

  localparam int unsigned N_MOD        = 2;
  localparam int unsigned CLK_HZ       = 4;
  localparam int unsigned GAME_SECONDS = 5;
  localparam int unsigned MAX_STRIKES  = 3;
  localparam int unsigned ARM_TIMEOUT  = 8;

  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DEFUSED = 3, P_EXPLODED = 4, P_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mod_activated, mod_failed, mod_solved;
  logic [5:0] mod_state;
  logic [2:0] game_state;
  logic [9:0] time_left;
  logic [1:0] strikes;
  logic       sec_tick, defused, exploded, arm_fault;

  always #5 clk = ~clk;

  bomb_game_ctrl #(
    .N_MOD(N_MOD), .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_SECONDS),
    .MAX_STRIKES(MAX_STRIKES), .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mod_activated(mod_activated), .mod_failed(mod_failed), .mod_solved(mod_solved),
    .mod_state(mod_state), .game_state(game_state), .time_left(time_left),
    .strikes(strikes), .sec_tick(sec_tick), .defused(defused),
    .exploded(exploded), .arm_fault(arm_fault)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- game-rule model ----------------
  int m_phase, m_strikes, m_time, m_tick, m_armc;
  bit m_ack[N_MOD];
  bit m_solved[N_MOD];
  bit m_prev_start, m_sec;

  function automatic void model_reset();
    m_phase = P_IDLE; m_strikes = 0; m_time = int'(GAME_SECONDS);
    m_tick = 0; m_armc = 0; m_prev_start = 0; m_sec = 0;
    for (int i = 0; i < int'(N_MOD); i++) begin m_ack[i] = 0; m_solved[i] = 0; end
  endfunction

  function automatic void model_step(input bit st, input logic [1:0] a,
                                     input logic [1:0] f, input logic [1:0] s);
    bit rise;
    bit all;
    int nf, old, div;
    rise = st && !m_prev_start;
    m_prev_start = st;
    m_sec = 0;
    case (m_phase)
      P_ARM: begin
        all = 1;
        for (int i = 0; i < int'(N_MOD); i++) begin
          if (a[i]) m_ack[i] = 1;
          if (!m_ack[i]) all = 0;
        end
        if (all) m_phase = P_RUN;
        else begin
          m_armc++;
          if (m_armc >= int'(ARM_TIMEOUT)) m_phase = P_FAULT;
        end
      end
      P_RUN: begin
        all = 1;
        for (int i = 0; i < int'(N_MOD); i++) if (!m_solved[i]) all = 0;
        if (m_strikes >= int'(MAX_STRIKES) || m_time == 0) m_phase = P_EXPLODED;
        else if (all) m_phase = P_DEFUSED;
        else begin
          nf = 0;
          for (int i = 0; i < int'(N_MOD); i++) if (f[i] && !m_solved[i]) nf++;
          for (int i = 0; i < int'(N_MOD); i++) if (s[i]) m_solved[i] = 1;
          old = m_strikes;
          m_strikes = (old + nf > int'(MAX_STRIKES)) ? int'(MAX_STRIKES) : old + nf;
          div = int'(CLK_HZ);
`ifdef STRIKE_SPEEDUP_EN
          div = int'(CLK_HZ >> old);
`endif
          if (div < 1) div = 1;
          m_tick++;
          if (m_tick >= div) begin
            m_tick = 0;
            if (m_time > 0) begin m_time--; m_sec = 1; end
          end
`ifdef STRIKE_SPEEDUP_EN
          if (m_strikes != old) m_tick = 0;
`endif
        end
      end
      default: begin
        if (rise) begin
          m_phase = P_ARM; m_strikes = 0; m_tick = 0; m_armc = 0;
          m_time = int'(GAME_SECONDS);
          for (int i = 0; i < int'(N_MOD); i++) begin m_ack[i] = 0; m_solved[i] = 0; end
        end
      end
    endcase
  endfunction

  function automatic logic [5:0] model_mod_state();
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < int'(N_MOD); i++) begin
      if (m_phase == P_ARM)      r[3*i +: 3] = 3'd1;
      else if (m_phase == P_RUN) r[3*i +: 3] = m_solved[i] ? 3'd3 : 3'd2;
    end
    return r;
  endfunction

  task automatic check_model();
    check("game_state", 32'(game_state), 32'(m_phase));
    check("mod_state",  32'(mod_state),  32'(model_mod_state()));
    check("time_left",  32'(time_left),  32'(m_time));
    check("strikes",    32'(strikes),    32'(m_strikes));
    check("sec_tick",   32'(sec_tick),   32'(m_sec));
    check("defused",    32'(defused),    32'(m_phase == P_DEFUSED));
    check("exploded",   32'(exploded),   32'(m_phase == P_EXPLODED));
    check("arm_fault",  32'(arm_fault),  32'(m_phase == P_FAULT));
  endtask

  // One clock: apply inputs, advance the model, compare just after the edge
  task automatic cyc(input bit st, input logic [1:0] a, input logic [1:0] f, input logic [1:0] s);
    start = st; mod_activated = a; mod_failed = f; mod_solved = s;
    @(posedge clk);
    model_step(st, a, f, s);
    #1;
    check_model();
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once
  task automatic do_reset();
    #2;
    start = 0; mod_activated = '0; mod_failed = '0; mod_solved = '0;
    rst = 1'b0;
    #1;
    model_reset();
    check_model();
    check("rst_state", 32'(game_state), 32'(0));
    check("rst_time",  32'(time_left),  32'(GAME_SECONDS));
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         st;
    logic [1:0] act, fl, sv;
    logic [2:0] e_state;
    logic [5:0] e_mod;
    logic [1:0] e_strk;
    logic [9:0] e_time;
    logic [2:0] e_flags;  // {arm_fault, exploded, defused}
  } vec_t;

  localparam int NV = 18;
`ifdef STRIKE_SPEEDUP_EN
  localparam logic [9:0] T10 = 10'd4;
`else
  localparam logic [9:0] T10 = 10'd5;
`endif

  vec_t tbl[NV];

  initial begin
    int cnt, ticks, gap;
    bit done;

    rst = 1'b1; start = 0; mod_activated = '0; mod_failed = '0; mod_solved = '0;
    model_reset();
    #2 rst = 1'b0;
    #1;
    check_model();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    //           st act fl  sv  state mod    strk time flags
    tbl[0]  = '{1, 0,  0,  0,  1, 6'h09, 0, 5,   0};  // start edge -> ARM
    tbl[1]  = '{0, 3,  0,  0,  2, 6'h12, 0, 5,   0};  // both ack -> RUN
    tbl[2]  = '{0, 0,  0,  1,  2, 6'h13, 0, 5,   0};
    tbl[3]  = '{0, 0,  0,  0,  2, 6'h13, 0, 5,   0};
    tbl[4]  = '{0, 0,  0,  2,  2, 6'h1B, 0, 5,   0};
    tbl[5]  = '{0, 0,  0,  0,  3, 6'h00, 0, 5,   1};  // defused
    tbl[6]  = '{1, 0,  0,  0,  1, 6'h09, 0, 5,   0};  // restart
    tbl[7]  = '{0, 1,  0,  0,  1, 6'h09, 0, 5,   0};  // sticky ack
    tbl[8]  = '{0, 2,  0,  0,  2, 6'h12, 0, 5,   0};
    tbl[9]  = '{0, 0,  3,  0,  2, 6'h12, 2, 5,   0};  // two fails at once
    tbl[10] = '{0, 0,  2,  1,  2, 6'h13, 3, T10, 0};  // third strike with solve
    tbl[11] = '{0, 0,  0,  0,  4, 6'h00, 3, T10, 2};  // exploded
    tbl[12] = '{1, 0,  0,  0,  1, 6'h09, 0, 5,   0};
    tbl[13] = '{0, 3,  0,  0,  2, 6'h12, 0, 5,   0};
    tbl[14] = '{0, 0,  0,  1,  2, 6'h13, 0, 5,   0};
    tbl[15] = '{0, 0,  1,  0,  2, 6'h13, 0, 5,   0};  // fail on solved module
    tbl[16] = '{0, 0,  2,  2,  2, 6'h1B, 1, 5,   0};
    tbl[17] = '{0, 0,  0,  0,  3, 6'h00, 1, 5,   1};

    for (int k = 0; k < NV; k++) begin
      cyc(tbl[k].st, tbl[k].act, tbl[k].fl, tbl[k].sv);
      check($sformatf("tbl%0d_state", k), 32'(game_state), 32'(tbl[k].e_state));
      check($sformatf("tbl%0d_mod", k),   32'(mod_state),  32'(tbl[k].e_mod));
      check($sformatf("tbl%0d_strk", k),  32'(strikes),    32'(tbl[k].e_strk));
      check($sformatf("tbl%0d_time", k),  32'(time_left),  32'(tbl[k].e_time));
      check($sformatf("tbl%0d_flags", k), 32'({arm_fault, exploded, defused}), 32'(tbl[k].e_flags));
    end

    // Timer expiry: 5 ticks of 4 cycles, explode one cycle after reaching 0
    cyc(1, 0, 0, 0);
    cyc(0, 3, 0, 0);
    cnt = -1; ticks = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(0, 0, 0, 0);
      if (sec_tick) ticks++;
      if (game_state == 3'd4) begin cnt = k; break; end
    end
    check("expiry_cycles", 32'(cnt), 32'(21));
    check("expiry_ticks", 32'(ticks), 32'(5));
    check("expiry_time", 32'(time_left), 32'(0));
    check("expiry_flag", 32'(exploded), 32'(1));

    // Arm fault: only module 0 acknowledges
    cyc(1, 0, 0, 0);
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 1, 0, 0);
      if (game_state == 3'd5) begin cnt = k; break; end
    end
    check("fault_cycles", 32'(cnt), 32'(ARM_TIMEOUT));
    check("fault_flag", 32'(arm_fault), 32'(1));
    cyc(1, 0, 0, 0);
    check("rearm_state", 32'(game_state), 32'(1));
    check("rearm_strikes", 32'(strikes), 32'(0));
    check("rearm_time", 32'(time_left), 32'(5));

    // Tick period after one strike
    cyc(0, 3, 0, 0);
    cyc(0, 0, 1, 0);
    gap = -1; done = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 0, 0);
      if (sec_tick && !done) begin gap = k; done = 1; end
      if (done) break;
    end
`ifdef STRIKE_SPEEDUP_EN
    check("strike_tick_gap", 32'(gap), 32'(2));
`else
    check("strike_tick_gap", 32'(gap), 32'(3));
`endif

    // Reset in the middle of RUN
    cyc(0, 0, 1, 0);
    do_reset();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] a, f, s;
      bit st;
      st = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 2; i++) begin
        a[i] = ($urandom_range(0, 2) == 0);
        f[i] = ($urandom_range(0, 9) == 0);
        s[i] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc(st, a, f, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1);
  end

endmodule
